message_scroller: RTL and testbench

Consumes the divided scroll clock from the clock divider and turns it into a scrolling text window on the seven-segment bank. It synchronizes the slow `scroll_clk` into the `clk_in` domain and detects its rising edges. On each edge it advances a circular read pointer over a writable message buffer, dwelling at the message start, and drives registered active-low segment patterns for `NUM_DIGITS` displays.

---
 rtl/message_scroller.sv | 220 ++++++++++++++++++++++
 tb/tb_message_scroller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/message_scroller.sv
// Scrolling seven-segment text window driven by an asynchronous scroll clock.
// Define SCROLLER_DEFAULT_MSG_EN to preload "HELL0-" into the buffer at reset.
module message_scroller #(
    parameter int MSG_LEN     = 16,
    parameter int NUM_DIGITS  = 6,
    parameter int DWELL_STEPS = 3,
    localparam int AW = $clog2(MSG_LEN)
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    scroll_clk,
    input  logic                    enable,
    input  logic                    direction,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [4:0]              wr_data,
    output logic [7*NUM_DIGITS-1:0] segs,
    output logic [AW-1:0]           position,
    output logic                    step
);

    localparam int CW = (DWELL_STEPS < 1) ? 1 : $clog2(DWELL_STEPS + 1);
    localparam logic [AW:0]   LEN_W = (AW + 1)'(MSG_LEN);
    localparam logic [AW-1:0] LAST  = AW'(MSG_LEN - 1);
    localparam logic [CW-1:0] DW_C  = CW'(DWELL_STEPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DWELL
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_prime;
    logic r_armed;
    logic w_edge;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [AW-1:0] r_pos;
    logic [AW-1:0] w_pos_nxt;
    logic [AW-1:0] w_pos_mv;
    logic          r_step;
    logic          w_step_nxt;
    logic          w_wr_ok;

    logic [4:0]              r_msg [MSG_LEN];
    logic [7*NUM_DIGITS-1:0] r_segs;
    logic [7*NUM_DIGITS-1:0] w_segs_nxt;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        logic [6:0] g;
        case (c)
            5'h00: g = 7'h40;
            5'h01: g = 7'h79;
            5'h02: g = 7'h24;
            5'h03: g = 7'h30;
            5'h04: g = 7'h19;
            5'h05: g = 7'h12;
            5'h06: g = 7'h02;
            5'h07: g = 7'h78;
            5'h08: g = 7'h00;
            5'h09: g = 7'h10;
            5'h0A: g = 7'h08;
            5'h0B: g = 7'h03;
            5'h0C: g = 7'h46;
            5'h0D: g = 7'h21;
            5'h0E: g = 7'h06;
            5'h0F: g = 7'h0E;
            5'h11: g = 7'h09;
            5'h12: g = 7'h47;
            5'h13: g = 7'h0C;
            5'h14: g = 7'h41;
            5'h15: g = 7'h2F;
            5'h16: g = 7'h2B;
            5'h17: g = 7'h23;
            5'h18: g = 7'h3F;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    function automatic logic [AW-1:0] wrap_add(
        input logic [AW-1:0] p,
        input int            j
    );
        logic [AW:0] s;
        s = {1'b0, p} + (AW + 1)'(j);
        if (s >= LEN_W) s = s - LEN_W;
        return s[AW-1:0];
    endfunction

    // The armed flag blocks a false edge when scroll_clk is already
    // high as reset releases: a low level must be seen first.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_prime <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s1    <= scroll_clk;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_prime <= 1'b1;
            r_armed <= r_armed | (r_prime & ~r_s1);
        end
    end

    assign w_edge    = r_s2 & ~r_s3 & r_armed;
    assign w_cnt_inc = r_cnt + CW'(1);

    always_comb begin
        if (direction) begin
            w_pos_mv = (r_pos == '0) ? LAST : r_pos - AW'(1);
        end else begin
            w_pos_mv = (r_pos == LAST) ? '0 : r_pos + AW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        w_step_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_edge) begin
                    w_step_nxt = 1'b1;
                    w_pos_nxt  = w_pos_mv;
                    if (w_pos_mv == '0) begin
                        w_state_nxt = S_DWELL;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_DWELL: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (DWELL_STEPS == 0) begin
                    w_state_nxt = S_RUN;
                end else if (w_edge) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == DW_C) w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < LEN_W);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSG_LEN; i++) r_msg[i] <= 5'h10;
`ifdef SCROLLER_DEFAULT_MSG_EN
            r_msg[0] <= 5'h11;
            r_msg[1] <= 5'h0E;
            r_msg[2] <= 5'h12;
            r_msg[3] <= 5'h12;
            r_msg[4] <= 5'h00;
            r_msg[5] <= 5'h18;
`endif
        end else if (w_wr_ok) begin
            r_msg[wr_addr] <= wr_data;
        end
    end

    // Leftmost digit shows the character at the pointer.
    always_comb begin
        w_segs_nxt = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            w_segs_nxt[7*(NUM_DIGITS-1-j) +: 7] =
                glyph(r_msg[wrap_add(r_pos, j)]);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_segs <= '1;
        end else begin
            r_segs <= w_segs_nxt;
        end
    end

    assign segs     = r_segs;
    assign position = r_pos;
    assign step     = r_step;

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller: spec-level model compared every cycle,
// plus directed scroll/write/reset scenarios with literal expectations.
module tb_message_scroller;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        scroll_clk = 1'b0;
    logic        enable = 1'b1;
    logic        direction = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [4:0]  wr_data = '0;
    logic [41:0] segs;
    logic [3:0]  position;
    logic        step;

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    message_scroller #(
        .MSG_LEN    (16),
        .NUM_DIGITS (6),
        .DWELL_STEPS(3)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .scroll_clk(scroll_clk),
        .enable    (enable),
        .direction (direction),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .segs      (segs),
        .position  (position),
        .step      (step)
    );

    always #5 clk_in = ~clk_in;

    localparam logic [6:0] GLYPH [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h7F, 7'h09, 7'h47, 7'h0C, 7'h41, 7'h2F, 7'h2B, 7'h23,
        7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
            end
        end
    endtask

    // Model: mode 0 idle, 1 run, 2 dwell. A scroll rise first sampled at
    // edge k is acted on at edge k+2; after reset a low must be seen first.
    int         m_mode, m_pos, m_cnt;
    logic       m_prev, m_ra, m_rb, m_step;
    logic [41:0] m_segs;
    logic [4:0] m_msg [16];

    int          n_mode, n_pos, n_cnt;
    logic        n_step;
    logic [41:0] n_segs;

    always_comb begin
        n_mode = m_mode;
        n_pos  = m_pos;
        n_cnt  = m_cnt;
        n_step = 1'b0;
        n_segs = '1;
        if (m_mode == 0) begin
            if (enable) n_mode = 1;
        end else if (m_mode == 1) begin
            if (!enable) begin
                n_mode = 0;
            end else if (m_rb) begin
                n_step = 1'b1;
                n_pos  = direction ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
                if (n_pos == 0) begin
                    n_mode = 2;
                    n_cnt  = 0;
                end
            end
        end else begin
            if (!enable) begin
                n_mode = 0;
                n_cnt  = 0;
            end else if (m_rb) begin
                n_cnt = m_cnt + 1;
                if (n_cnt == 3) n_mode = 1;
            end
        end
        for (int j = 0; j < 6; j++)
            n_segs[7*(5-j) +: 7] = GLYPH[m_msg[(m_pos + j) % 16]];
    end

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            m_prev <= 1'b1;
            m_ra   <= 1'b0;
            m_rb   <= 1'b0;
            m_mode <= 0;
            m_pos  <= 0;
            m_cnt  <= 0;
            m_step <= 1'b0;
            m_segs <= '1;
            for (int i = 0; i < 16; i++) m_msg[i] <= 5'h10;
`ifdef SCROLLER_DEFAULT_MSG_EN
            m_msg[0] <= 5'h11;
            m_msg[1] <= 5'h0E;
            m_msg[2] <= 5'h12;
            m_msg[3] <= 5'h12;
            m_msg[4] <= 5'h00;
            m_msg[5] <= 5'h18;
`endif
        end else begin
            m_prev <= scroll_clk;
            m_ra   <= scroll_clk & ~m_prev;
            m_rb   <= m_ra;
            m_mode <= n_mode;
            m_pos  <= n_pos;
            m_cnt  <= n_cnt;
            m_step <= n_step;
            m_segs <= n_segs;
            if (wr_en) m_msg[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk_in) begin
        chk("segs", 64'(segs), 64'(m_segs));
        chk("position", 64'(position), 64'(m_pos[3:0]));
        chk("step", 64'(step), 64'(m_step));
    end

    // One scroll period: 3 cycles high, 3 low. Optional write lands on
    // the same clock edge as the resulting step.
    task automatic pulse(input bit dow, input logic [3:0] a,
                         input logic [4:0] d, output int ns);
        ns = 0;
        scroll_clk = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_in);
            if (step) ns++;
            if (i == 2 && dow) begin
                wr_en   = 1'b1;
                wr_addr = a;
                wr_data = d;
            end
            if (i == 3) begin
                wr_en      = 1'b0;
                scroll_clk = 1'b0;
            end
        end
    endtask

    task automatic pulses(input int n, input int exp_steps,
                          input int exp_pos, input string nm);
        int ns, tot;
        tot = 0;
        for (int i = 0; i < n; i++) begin
            pulse(1'b0, 4'd0, 5'd0, ns);
            tot += ns;
        end
        chk({nm, "_steps"}, 64'(tot), 64'(exp_steps));
        chk({nm, "_pos"}, 64'(position), 64'(exp_pos));
    endtask

    localparam logic [4:0] HELLO [6] = '{5'h11, 5'h0E, 5'h12, 5'h12,
                                         5'h00, 5'h18};

    initial begin
        int ns;
        logic [41:0] exp_w;
        repeat (3) @(negedge clk_in);
        chk("rst_segs", 64'(segs), 64'h3FF_FFFF_FFFF);
        chk("rst_pos", 64'(position), 64'd0);
        chk("rst_step", 64'(step), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = HELLO[i];
        end
        @(negedge clk_in);
        wr_en = 1'b0;
        repeat (2) @(negedge clk_in);
        exp_w = {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h3F};
        chk("hello_segs", 64'(segs), 64'(exp_w));

        pulse(1'b0, 4'd0, 5'd0, ns);
        chk("p1_steps", 64'(ns), 64'd1);
        chk("p1_pos", 64'(position), 64'd1);
        exp_w = {7'h06, 7'h47, 7'h47, 7'h40, 7'h3F, 7'h7F};
        chk("p1_segs", 64'(segs), 64'(exp_w));

        pulse(1'b1, 4'd2, 5'h13, ns);
        chk("wr_steps", 64'(ns), 64'd1);
        chk("wr_pos", 64'(position), 64'd2);
        chk("wr_left", 64'(segs[41:35]), 64'h0C);

        pulses(13, 13, 15, "to15");
        pulses(1, 1, 0, "wrap0");
        pulses(3, 0, 0, "dwell");
        pulses(1, 1, 1, "exit");

        direction = 1'b1;
        @(negedge clk_in);
        pulses(1, 1, 0, "dn0");
        pulses(3, 0, 0, "dn_dwell");
        pulses(1, 1, 15, "dn15");
        pulses(15, 15, 0, "dn_run");
        pulses(1, 0, 0, "dn_dwell2");

        scroll_clk = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("mid_rst_pos", 64'(position), 64'd0);
        chk("mid_rst_segs", 64'(segs), 64'h3FF_FFFF_FFFF);
        reset = 1'b1;
        ns = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (step) ns++;
        end
        chk("held_hi_steps", 64'(ns), 64'd0);
        chk("held_hi_pos", 64'(position), 64'd0);
        scroll_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        pulses(1, 1, 15, "fresh");

        enable = 1'b0;
        @(negedge clk_in);
        pulses(1, 0, 15, "freeze");
        enable = 1'b1;
        @(negedge clk_in);
        pulses(1, 1, 14, "resume");

        repeat (3) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
